lbp_image_host: RTL and testbench

Memory-side responder for the LBP engine's gray-read and lbp-write interfaces. It accepts a raster-order grayscale image from an upstream pixel stream and stores it. It then raises gray_ready and serves the engine's gray_addr reads. It captures every lbp_valid write into a result buffer, and after the engine asserts finish it streams the result image out in raster order.

---
 rtl/lbp_image_host.sv | 148 ++++++++++++++
 tb/tb_lbp_image_host.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_image_host.sv
// ----------------------------------------------------------------------------
// lbp_image_host
//
// Memory-side responder for the LBP engine. It loads a raster-order grayscale
// image from an upstream stream, serves the engine's gray reads, captures the
// engine's lbp writes, and after the engine signals finish it streams the
// result image out in raster order.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_data/in_ready  upstream gray pixel stream (raster order)
//   gray_ready                 image fully loaded, engine may start
//   gray_req/gray_addr         engine read port, address {row,col}
//   gray_data                  registered read data (latency 1)
//   lbp_valid/lbp_addr/lbp_data engine write port into the result buffer
//   finish                     engine done, starts the result dump
//   out_valid/out_data/out_last/out_ready  result stream, ready/valid
//   wr_count                   lbp writes captured while serving (saturating)
//   done                       result dump complete, sticky until reset
// ----------------------------------------------------------------------------
module lbp_image_host #(
   parameter int ROW_W  = 7,
   parameter int COL_W  = 7,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     gray_ready,
   input  logic                     gray_req,
   input  logic [ROW_W+COL_W-1:0]   gray_addr,
   output logic [DATA_W-1:0]        gray_data,
   input  logic                     lbp_valid,
   input  logic [ROW_W+COL_W-1:0]   lbp_addr,
   input  logic [DATA_W-1:0]        lbp_data,
   input  logic                     finish,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic [ROW_W+COL_W:0]     wr_count,
   output logic                     done
);

   localparam int AW = ROW_W + COL_W;
   localparam int N  = 2 ** AW;
   // Pixel count as a counter value: one bit wider than an address.
   localparam logic [AW:0] N_CNT = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = (AW+1)'(1);

   typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DUMP, S_DONE} state_t;

   state_t            state;
   logic [AW:0]       load_cnt;
   logic [AW:0]       dump_cnt;   // next result address to fetch
   logic [DATA_W-1:0] gray_mem [N];
   logic [DATA_W-1:0] lbp_mem  [N];

   logic load_acc;
   logic lbp_wr;
   logic out_free;

   assign load_acc = (state == S_LOAD) && in_valid && in_ready;
   assign lbp_wr   = (state == S_SERVE) && lbp_valid;
   // Output register can take a new beat: empty or being consumed now.
   assign out_free = !out_valid || out_ready;

   // Storage arrays carry no reset; their contents are only trusted after
   // a complete load / capture in the current session.
   always_ff @(posedge clk) begin
      if (load_acc)
         gray_mem[load_cnt[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (lbp_wr)
         lbp_mem[lbp_addr] <= lbp_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_LOAD;
         in_ready   <= 1'b0;
         gray_ready <= 1'b0;
         gray_data  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         wr_count   <= '0;
         done       <= 1'b0;
         load_cnt   <= '0;
         dump_cnt   <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (load_cnt == N_CNT) begin
                  // Full image held; in_ready already dropped last cycle.
                  state      <= S_SERVE;
                  gray_ready <= 1'b1;
               end else begin
                  // Drop ready on the cycle the final pixel is accepted so
                  // no extra pixel can slip in.
                  in_ready <= !(load_acc && (load_cnt == N_CNT - ONE));
                  if (load_acc)
                     load_cnt <= load_cnt + ONE;
               end
            end

            S_SERVE: begin
               if (gray_req)
                  gray_data <= gray_mem[gray_addr];
               if (lbp_valid && (wr_count != N_CNT))
                  wr_count <= wr_count + ONE;
               // A write in the finish cycle is still captured above.
               if (finish) begin
                  state      <= S_DUMP;
                  gray_ready <= 1'b0;
               end
            end

            S_DUMP: begin
               if (out_valid && out_ready && out_last) begin
                  state     <= S_DONE;
                  out_valid <= 1'b0;
                  done      <= 1'b1;
               end else if (out_free) begin
                  // The last beat stalls the pipe until its handshake, so
                  // dump_cnt never fetches past N-1.
                  out_valid <= 1'b1;
                  out_data  <= lbp_mem[dump_cnt[AW-1:0]];
                  out_last  <= (dump_cnt[AW-1:0] == {AW{1'b1}});
                  dump_cnt  <= dump_cnt + ONE;
               end
            end

            S_DONE: begin
               out_valid <= 1'b0;
               done      <= 1'b1;
            end

            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_lbp_image_host.sv
// ----------------------------------------------------------------------------
// tb_lbp_image_host
//
// Directed bench for lbp_image_host. A 4x4 instance (N = 16) runs load,
// serve, dump and a mid-dump reset; a default-size instance checks the top
// address after a full 16K-pixel load. A behavioural image/result model is
// compared against the 4x4 outputs every cycle, and literal values pin the
// model to hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_lbp_image_host;

   localparam int N = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4x4 instance
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready, gray_ready, gray_req;
   logic [3:0] gray_addr;
   logic [7:0] gray_data;
   logic       lbp_valid;
   logic [3:0] lbp_addr;
   logic [7:0] lbp_data;
   logic       finish, out_valid;
   logic [7:0] out_data;
   logic       out_last, out_ready;
   logic [4:0] wr_count;
   logic       done;

   // default-size instance
   logic        b_reset, b_in_valid, b_in_ready, b_gray_ready, b_gray_req;
   logic [7:0]  b_in_data, b_gray_data, b_lbp_data, b_out_data;
   logic [13:0] b_gray_addr, b_lbp_addr;
   logic        b_lbp_valid, b_finish, b_out_valid, b_out_last, b_out_ready, b_done;
   logic [14:0] b_wr_count;

   lbp_image_host #(.ROW_W(2), .COL_W(2), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .gray_ready(gray_ready), .gray_req(gray_req),
      .gray_addr(gray_addr), .gray_data(gray_data), .lbp_valid(lbp_valid),
      .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .wr_count(wr_count), .done(done)
   );

   lbp_image_host dut_big (
      .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .gray_ready(b_gray_ready), .gray_req(b_gray_req),
      .gray_addr(b_gray_addr), .gray_data(b_gray_data), .lbp_valid(b_lbp_valid),
      .lbp_addr(b_lbp_addr), .lbp_data(b_lbp_data), .finish(b_finish),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
      .out_ready(b_out_ready), .wr_count(b_wr_count), .done(b_done)
   );

   // ---------------- model ----------------
   logic [7:0] gray_m [N];
   logic [7:0] lbp_m  [N];
   logic [7:0] got    [N];
   bit         got_last [N];
   int         ph;          // 0 load, 1 serve, 2 dump
   int         beat;        // result handshakes so far
   int         exp_wr;
   logic [7:0] exp_gray;
   logic [7:0] hold_data;
   bit         hold_last, stalled, seen_v, mon_on;
   int         n_cmp, n_err;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph = 0; beat = 0; exp_wr = 0; exp_gray = 8'h00;
      stalled = 0; seen_v = 0;
   endtask

   // Single compare process: outputs checked mid-cycle, then the model
   // advances using the inputs that will be sampled at the next edge.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("gray_data", gray_data, exp_gray);
         chk("wr_count", wr_count, exp_wr);
         chk("gray_ready", gray_ready, ph == 1);
         chk("done", done, beat == N);
         if (ph != 2 || beat == N) begin
            chk("out_valid_idle", out_valid, 0);
         end else begin
            if (seen_v) chk("out_valid_held", out_valid, 1);
            if (out_valid) begin
               seen_v = 1;
               if (stalled) begin
                  chk("stall_data", out_data, hold_data);
                  chk("stall_last", out_last, hold_last);
               end
               chk("beat_data", out_data, lbp_m[beat]);
               chk("beat_last", out_last, beat == N-1);
               stalled   = !out_ready;
               hold_data = out_data;
               hold_last = out_last;
               if (out_ready) begin
                  got[beat] = out_data;
                  got_last[beat] = out_last;
                  beat++;
               end
            end
         end
         if (ph == 1 && gray_req) exp_gray = gray_m[gray_addr];
         if (ph == 1 && lbp_valid) begin
            lbp_m[lbp_addr] = lbp_data;
            if (exp_wr < N) exp_wr++;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic load_img(input logic [7:0] base, input bit gaps);
      int n = 0;
      int cyc = 0;
      while (n < N && cyc < 400) begin
         in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data   = base + 8'(n);
         lbp_valid = gaps && ($urandom_range(0, 3) == 0);
         lbp_addr  = 4'($urandom_range(0, 15));
         lbp_data  = 8'hEE;
         finish    = gaps && ($urandom_range(0, 4) == 0);
         @(negedge clk);
         chk("in_ready_load", in_ready, 1);
         if (in_valid && in_ready) begin
            gray_m[n] = in_data;
            n++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (n != N) chk("load_timeout", n, N);
      // Extra pixel after the image is full must be ignored.
      in_valid = 1'b1; in_data = 8'hEE; lbp_valid = 1'b0; finish = 1'b0;
      chk("in_ready_drop", in_ready, 0);
      chk("gray_ready_wait", gray_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("gray_ready_rise", gray_ready, 1);
      ph = 1;
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] lit);
      gray_req = 1'b1; gray_addr = a;
      @(posedge clk); #1;
      chk("rd_lit", gray_data, lit);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit fin);
      lbp_valid = 1'b1; lbp_addr = a; lbp_data = d; finish = fin;
      @(posedge clk); #1;
      lbp_valid = 1'b0; finish = 1'b0;
      if (fin) ph = 2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_gray_ready", gray_ready, 0);
      chk("rst_gray_data", gray_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_done", done, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_rst", in_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int acc;
      n_cmp = 0; n_err = 0; mon_on = 0;
      model_reset();
      in_valid = 0; in_data = 0; gray_req = 0; gray_addr = 0;
      lbp_valid = 0; lbp_addr = 0; lbp_data = 0; finish = 0; out_ready = 0;
      b_reset = 1; b_in_valid = 0; b_in_data = 0; b_gray_req = 0; b_gray_addr = 0;
      b_lbp_valid = 0; b_lbp_addr = 0; b_lbp_data = 0; b_finish = 0; b_out_ready = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      mon_on = 1;
      do_reset();

      // Load with gaps and junk engine strobes, then basic reads.
      load_img(8'h10, 1'b1);
      rd(4'd5, 8'h15);
      rd(4'd15, 8'h1F);
      rd(4'd3, 8'h13);
      gray_req = 1'b0; gray_addr = 4'd9;
      repeat (3) begin
         @(posedge clk); #1;
         chk("gray_hold", gray_data, 8'h13);
      end
      rd(4'd0, 8'h10);
      rd(4'd1, 8'h11);
      rd(4'd2, 8'h12);
      for (int i = 0; i < N; i++) rd(4'(i), 8'h10 + 8'(i));
      gray_req = 1'b0;

      // Writes, one overlapped with a read, then finish with the last write.
      gray_req = 1'b1; gray_addr = 4'd7;
      wr(4'd4, 8'hAA, 1'b0);
      gray_req = 1'b0;
      chk("rd_during_wr", gray_data, 8'h17);
      wr(4'd4, 8'h55, 1'b0);
      for (int i = 0; i < N; i++) wr(4'(i), 8'(i) ^ 8'hF0, i == N-1);
      chk("wr_count_sat", wr_count, 16);

      // Dump: must start within 2 cycles, stall 5, then toggle ready.
      k = 0;
      while (!out_valid && k < 2) begin
         @(posedge clk); #1;
         k++;
      end
      chk("out_valid_rise", out_valid, 1);
      chk("first_beat", out_data, 8'hF0);
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_first", out_data, 8'hF0);
      end
      k = 0;
      while (!done && k < 200) begin
         out_ready = ~out_ready;
         @(posedge clk); #1;
         k++;
      end
      out_ready = 1'b0;
      chk("beats", beat, 16);
      chk("done_set", done, 1);
      chk("beat4", got[4], 8'hF4);
      chk("beat15", got[15], 8'hFF);
      chk("last15", got_last[15], 1);
      chk("last14", got_last[14], 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_sticky", done, 1);

      // Second session: reset mid-dump after 7 beats.
      do_reset();
      load_img(8'h40, 1'b0);
      wr(4'd2, 8'h77, 1'b0);
      wr(4'd9, 8'h99, 1'b1);
      out_ready = 1'b1;
      k = 0;
      while (beat < 7 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("beats_before_rst", beat, 7);
      chk("beat2_second", got[2], 8'h77);
      out_ready = 1'b0;
      do_reset();
      load_img(8'h80, 1'b1);
      rd(4'd0, 8'h80);
      rd(4'd15, 8'h8F);
      gray_req = 1'b0;

      // Default-size image: top address returns the last pixel loaded.
      #1; b_reset = 1'b0;
      @(posedge clk); #1;
      acc = 0; k = 0;
      while (acc < 16384 && k < 20000) begin
         b_in_valid = 1'b1;
         b_in_data  = 8'(acc) ^ 8'h5A;
         @(negedge clk);
         if (b_in_ready) acc++;
         @(posedge clk); #1;
         k++;
      end
      b_in_valid = 1'b0;
      chk("big_loaded", acc, 16384);
      k = 0;
      while (!b_gray_ready && k < 5) begin
         @(posedge clk); #1;
         k++;
      end
      chk("big_gray_ready", b_gray_ready, 1);
      b_gray_req = 1'b1; b_gray_addr = 14'h3FFF;
      @(posedge clk); #1;
      chk("big_rd_top", b_gray_data, 8'hA5);
      b_gray_addr = 14'h0000;
      @(posedge clk); #1;
      chk("big_rd_zero", b_gray_data, 8'h5A);
      b_gray_req = 1'b0;
      chk("big_wr_count", b_wr_count, 0);
      chk("big_out_valid", b_out_valid, 0);
      chk("big_out_last", b_out_last, 0);
      chk("big_out_data", b_out_data, 0);
      chk("big_done", b_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
